// File: rtl/fc_engine_arbiter.sv
// Two-client arbiter in front of a shared FC engine: grants one client, streams
// its N input beats into the engine, then routes the engine's M results back.
module fc_engine_arbiter #(
  parameter int M = 16,
  parameter int N = 8,
  parameter int T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_in_valid,
  output logic         c0_in_ready,
  input  logic [T-1:0] c0_in_data,
  output logic         c0_out_valid,
  input  logic         c0_out_ready,
  output logic [T-1:0] c0_out_data,
  input  logic         c1_in_valid,
  output logic         c1_in_ready,
  input  logic [T-1:0] c1_in_data,
  output logic         c1_out_valid,
  input  logic         c1_out_ready,
  output logic [T-1:0] c1_out_data,
  output logic         eng_in_valid,
  input  logic         eng_in_ready,
  output logic [T-1:0] eng_in_data,
  input  logic         eng_out_valid,
  output logic         eng_out_ready,
  input  logic [T-1:0] eng_out_data,
  output logic         owner,
  output logic         busy,
  output logic         proto_err,
  output logic [1:0]   state_dbg
);

  // Handshake: every stream moves a beat on a rising clk edge where valid and
  // ready are both 1; valid never depends on ready on the sending side.

  localparam int IW = $clog2(N) + 1;
  localparam int OW = $clog2(M) + 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(N - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] in_cnt, in_cnt_nxt;
  logic [OW-1:0] out_cnt, out_cnt_nxt;
  logic          owner_q, owner_nxt;
  logic          last_grant, last_grant_nxt;
  logic          proto_err_q, proto_err_nxt;
  logic          sel_in_valid;
  logic          sel_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      owner_q     <= 1'b0;
      last_grant  <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_cnt      <= in_cnt_nxt;
      out_cnt     <= out_cnt_nxt;
      owner_q     <= owner_nxt;
      last_grant  <= last_grant_nxt;
      proto_err_q <= proto_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    in_cnt_nxt     = in_cnt;
    out_cnt_nxt    = out_cnt;
    owner_nxt      = owner_q;
    last_grant_nxt = last_grant;
    proto_err_nxt  = proto_err_q;
    c0_in_ready    = 1'b0;
    c1_in_ready    = 1'b0;
    c0_out_valid   = 1'b0;
    c1_out_valid   = 1'b0;
    c0_out_data    = '0;
    c1_out_data    = '0;
    eng_in_valid   = 1'b0;
    eng_in_data    = '0;
    eng_out_ready  = 1'b0;
    sel_in_valid   = owner_q ? c1_in_valid : c0_in_valid;
    sel_out_ready  = owner_q ? c1_out_ready : c0_out_ready;

    // Engine results are only legal while draining to the owner.
    if (eng_out_valid && (state != S_DRAIN)) proto_err_nxt = 1'b1;

    case (state)
      S_IDLE: begin
        if (c0_in_valid || c1_in_valid) begin
          state_nxt = S_LOAD;
          if (c0_in_valid && c1_in_valid) owner_nxt = ~last_grant;
          else                            owner_nxt = c1_in_valid;
        end
      end
      S_LOAD: begin
        eng_in_valid = sel_in_valid;
        if (sel_in_valid) eng_in_data = owner_q ? c1_in_data : c0_in_data;
        if (owner_q) c1_in_ready = eng_in_ready;
        else         c0_in_ready = eng_in_ready;
        if (sel_in_valid && eng_in_ready) begin
          if (in_cnt == IN_LAST) begin
            in_cnt_nxt = '0;
            state_nxt  = S_DRAIN;
          end else begin
            in_cnt_nxt = in_cnt + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        eng_out_ready = sel_out_ready;
        if (owner_q) begin
          c1_out_valid = eng_out_valid;
          if (eng_out_valid) c1_out_data = eng_out_data;
        end else begin
          c0_out_valid = eng_out_valid;
          if (eng_out_valid) c0_out_data = eng_out_data;
        end
        if (eng_out_valid && sel_out_ready) begin
          if (out_cnt == OUT_LAST) begin
            out_cnt_nxt    = '0;
            last_grant_nxt = owner_q;
            state_nxt      = S_IDLE;
          end else begin
            out_cnt_nxt = out_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign owner     = owner_q;
  assign busy      = (state != S_IDLE);
  assign proto_err = proto_err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_fc_engine_arbiter.sv
// Directed bench for fc_engine_arbiter: the bench plays both clients and the
// FC engine, and checks routing, grant order, masking and beat counts.
module tb_fc_engine_arbiter;
  localparam int M = 16;
  localparam int N = 8;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   c_in_valid, c_out_ready;
  logic [T-1:0] c0_in_data, c1_in_data;
  logic         eng_in_ready, eng_out_valid;
  logic [T-1:0] eng_out_data;
  logic         c0_in_ready, c1_in_ready, c0_out_valid, c1_out_valid;
  logic [T-1:0] c0_out_data, c1_out_data;
  logic         eng_in_valid, eng_out_ready;
  logic [T-1:0] eng_in_data;
  logic         owner, busy, proto_err;
  logic [1:0]   state_dbg;

  int   errors = 0;
  int   checks = 0;
  logic exp_proto = 1'b0;

  always #5 clk = ~clk;

  fc_engine_arbiter #(.M(M), .N(N), .T(T)) dut (
    .clk(clk), .reset(reset),
    .c0_in_valid(c_in_valid[0]), .c0_in_ready(c0_in_ready), .c0_in_data(c0_in_data),
    .c0_out_valid(c0_out_valid), .c0_out_ready(c_out_ready[0]), .c0_out_data(c0_out_data),
    .c1_in_valid(c_in_valid[1]), .c1_in_ready(c1_in_ready), .c1_in_data(c1_in_data),
    .c1_out_valid(c1_out_valid), .c1_out_ready(c_out_ready[1]), .c1_out_data(c1_out_data),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
    .owner(owner), .busy(busy), .proto_err(proto_err), .state_dbg(state_dbg)
  );

  function automatic logic in_rdy(input int k);
    return (k == 1) ? c1_in_ready : c0_in_ready;
  endfunction

  function automatic logic out_vld(input int k);
    return (k == 1) ? c1_out_valid : c0_out_valid;
  endfunction

  function automatic logic [T-1:0] out_dat(input int k);
    return (k == 1) ? c1_out_data : c0_out_data;
  endfunction

  task automatic set_in_data(input int k, input logic [T-1:0] d);
    if (k == 1) c1_in_data = d;
    else        c0_in_data = d;
  endtask

  task automatic idle_inputs();
    c_in_valid    = 2'b00;
    c_out_ready   = 2'b00;
    c0_in_data    = '0;
    c1_in_data    = '0;
    eng_in_ready  = 1'b0;
    eng_out_valid = 1'b0;
    eng_out_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_proto = 1'b0;
  endtask

  task automatic check_all_quiet(input string name);
    logic [5:0] ctl;
    ctl = {c0_in_ready, c1_in_ready, c0_out_valid, c1_out_valid, eng_in_valid, eng_out_ready};
    checks++;
    if (ctl !== 6'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL %s_ctl: got ctl=%b busy=%b state=%0d expected ctl=000000 busy=0 state=0",
               name, ctl, busy, state_dbg);
    end
    checks++;
    if (c0_out_data !== '0 || c1_out_data !== '0 || eng_in_data !== '0) begin
      errors++;
      $display("FAIL %s_data: got c0=%h c1=%h eng=%h expected all 0",
               name, c0_out_data, c1_out_data, eng_in_data);
    end
    checks++;
    if (owner !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_regs: got owner=%b proto_err=%b expected 0 0", name, owner, proto_err);
    end
  endtask

  // One transaction for client k. The bench acts as the engine: it accepts N
  // beats, then returns M results. abort_at >= 0 stops after that many results.
  task automatic run_txn(input int k, input logic other_req, input logic [T-1:0] in_base,
                         input logic [T-1:0] out_base, input bit toggle, input int stall_at,
                         input int proto_at, input int abort_at);
    int in_idx = 0, eng_in_cnt = 0, out_idx = 0, stall_left = 3, cyc = 0;
    bit in_fire, cli_fire, out_fire, stalling, pulse;
    while (out_idx < M && cyc < 200 && !(abort_at >= 0 && out_idx == abort_at)) begin
      c_in_valid[k] = (in_idx < N);
      set_in_data(k, (in_idx < N) ? T'(in_base + in_idx) : '0);
      c_in_valid[1-k] = other_req;
      set_in_data(1-k, T'(16'hE000 + cyc));
      eng_in_ready  = toggle ? (cyc % 2 == 1) : 1'b1;
      pulse         = (cyc == proto_at);
      eng_out_valid = ((eng_in_cnt == N) && (out_idx < M)) || pulse;
      eng_out_data  = pulse ? 16'h7777 : T'(out_base + out_idx);
      stalling      = (stall_at >= 0) && (out_idx >= stall_at) && (stall_left > 0) && (eng_in_cnt == N);
      c_out_ready[k]   = !stalling;
      c_out_ready[1-k] = 1'b1;
      #1;
      if (cyc == 0) begin
        checks++;
        if (in_rdy(k) !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL grant_idle: got in_ready=%b busy=%b expected 0 0", in_rdy(k), busy);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1 || owner !== k[0] || in_rdy(k) !== eng_in_ready) begin
          errors++;
          $display("FAIL grant_latency: got busy=%b owner=%b in_ready=%b expected 1 %0d %b",
                   busy, owner, in_rdy(k), k, eng_in_ready);
        end
      end
      checks++;
      if (out_vld(1-k) !== 1'b0 || out_dat(1-k) !== '0 || in_rdy(1-k) !== 1'b0) begin
        errors++;
        $display("FAIL nonowner_mask: got out_valid=%b out_data=%h in_ready=%b expected 0 0 0",
                 out_vld(1-k), out_dat(1-k), in_rdy(1-k));
      end
      checks++;
      if (proto_err !== exp_proto) begin
        errors++;
        $display("FAIL proto_err: got %b expected %b (cycle %0d)", proto_err, exp_proto, cyc);
      end
      checks++;
      if (eng_in_valid === 1'b0 && eng_in_data !== '0) begin
        errors++;
        $display("FAIL eng_in_data_mask: got %h expected 0", eng_in_data);
      end
      if (eng_in_cnt < N) begin
        checks++;
        if (eng_out_ready !== 1'b0 || out_vld(k) !== 1'b0 || out_dat(k) !== '0) begin
          errors++;
          $display("FAIL no_out_in_load: got eng_out_ready=%b out_valid=%b out_data=%h expected 0 0 0",
                   eng_out_ready, out_vld(k), out_dat(k));
        end
      end else begin
        checks++;
        if (eng_in_valid !== 1'b0 || in_rdy(k) !== 1'b0) begin
          errors++;
          $display("FAIL extra_in_beat: got eng_in_valid=%b in_ready=%b expected 0 0",
                   eng_in_valid, in_rdy(k));
        end
      end
      in_fire  = (eng_in_valid === 1'b1) && eng_in_ready;
      cli_fire = c_in_valid[k] && (in_rdy(k) === 1'b1);
      checks++;
      if (in_fire != cli_fire) begin
        errors++;
        $display("FAIL in_fire_match: got engine=%b client=%b expected equal", in_fire, cli_fire);
      end
      if (in_fire) begin
        checks++;
        if (eng_in_data !== T'(in_base + eng_in_cnt)) begin
          errors++;
          $display("FAIL in_data: got %h expected %h", eng_in_data, T'(in_base + eng_in_cnt));
        end
      end
      if (stalling) begin
        checks++;
        if (eng_out_ready !== 1'b0 || out_vld(k) !== 1'b1) begin
          errors++;
          $display("FAIL stall: got eng_out_ready=%b out_valid=%b expected 0 1", eng_out_ready, out_vld(k));
        end
      end
      out_fire = eng_out_valid && (eng_out_ready === 1'b1);
      if (out_fire) begin
        checks++;
        if (out_vld(k) !== 1'b1 || out_dat(k) !== T'(out_base + out_idx)) begin
          errors++;
          $display("FAIL out_data: got valid=%b data=%h expected 1 %h",
                   out_vld(k), out_dat(k), T'(out_base + out_idx));
        end
      end
      @(posedge clk);
      #1;
      if (in_fire) begin
        eng_in_cnt++;
        in_idx++;
      end
      if (out_fire) out_idx++;
      if (stalling) stall_left--;
      if (pulse) exp_proto = 1'b1;
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL txn_timeout: got %0d cycles expected < 200", cyc);
    end
    if (abort_at < 0) begin
      checks++;
      if (eng_in_cnt != N || out_idx != M) begin
        errors++;
        $display("FAIL beat_counts: got in=%0d out=%0d expected %0d %0d", eng_in_cnt, out_idx, N, M);
      end
      c_in_valid[k] = 1'b0;
      eng_out_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || state_dbg !== 2'd0) begin
        errors++;
        $display("FAIL busy_drop: got busy=%b state=%0d expected 0 0", busy, state_dbg);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_all_quiet("reset");
  endtask

  task automatic test_sole_request();
    run_txn(0, 1'b0, 16'd1, 16'd100, 1'b0, -1, -1, -1);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_txn(0, 1'b1, 16'h0010, 16'h0200, 1'b0, -1, -1, -1);
    run_txn(1, 1'b1, 16'h0020, 16'h0300, 1'b0, -1, -1, -1);
    idle_inputs();
  endtask

  task automatic test_back_pressure();
    @(posedge clk);
    #1;
    run_txn(0, 1'b0, 16'h0040, 16'h0400, 1'b1, 6, -1, -1);
    idle_inputs();
  endtask

  task automatic test_proto_err();
    @(posedge clk);
    #1;
    run_txn(0, 1'b0, 16'h0050, 16'h0500, 1'b0, -1, 3, -1);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: got %b expected 1", proto_err);
    end
    do_reset();
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_clear: got %b expected 0", proto_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    @(posedge clk);
    #1;
    run_txn(0, 1'b0, 16'h0060, 16'h0600, 1'b0, -1, -1, 5);
    checks++;
    if (state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL abort_in_drain: got state=%0d expected 2", state_dbg);
    end
    do_reset();
    #1;
    check_all_quiet("reset_mid_drain");
    run_txn(1, 1'b0, 16'h0A00, 16'h0B00, 1'b0, -1, -1, -1);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sole_request();
    test_back_to_back();
    test_back_pressure();
    test_proto_err();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
